// File: rtl/gas_engine_pkg.sv
// Shared constants for the gas window monitor: state encoding, default thresholds,
// the sample window width shared with the upstream shift register, and a saturating-increment helper.
package gas_engine_pkg;

  localparam int GAS_WIDTH       = 12;
  localparam int GAS_WARN_TH     = 4;
  localparam int GAS_ALARM_TH    = 8;
  localparam int GAS_HOLD_CYCLES = 16;

  localparam logic [1:0] SAFE  = 2'd0;
  localparam logic [1:0] WARN  = 2'd1;
  localparam logic [1:0] ALARM = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int LEAK_W = 8;

  function automatic logic [LEAK_W-1:0] sat_inc(input logic [LEAK_W-1:0] v);
    return (&v) ? v : v + LEAK_W'(1);
  endfunction

endpackage

// File: rtl/gas_popcount.sv
// Purely combinational ones count of a WIDTH-bit window; output is $clog2(WIDTH+1) bits wide.
module gas_popcount
  import gas_engine_pkg::*;
#(
  parameter int WIDTH = GAS_WIDTH
) (
  input  logic [WIDTH-1:0]           bits_i,
  output logic [$clog2(WIDTH+1)-1:0] count_o
);

  localparam int CW = $clog2(WIDTH+1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/gas_window_monitor.sv
// Counts ones in each accepted sample window and runs the SAFE/WARN/ALARM/HOLD valve FSM.
// leak_events counter is only built when GAS_EVENT_COUNTER_EN is defined; otherwise it reads 0.
module gas_window_monitor
  import gas_engine_pkg::*;
#(
  parameter int WIDTH       = GAS_WIDTH,
  parameter int WARN_TH     = GAS_WARN_TH,
  parameter int ALARM_TH    = GAS_ALARM_TH,
  parameter int HOLD_CYCLES = GAS_HOLD_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           window,
  input  logic                       sample_valid,
  input  logic                       ack,
  output logic [$clog2(WIDTH+1)-1:0] ones_count,
  output logic                       warn,
  output logic                       alarm,
  output logic                       valve_close,
  output logic [LEAK_W-1:0]          leak_events
);

  localparam int CW = $clog2(WIDTH+1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CW-1:0] WARN_C    = CW'(WARN_TH);
  localparam logic [CW-1:0] ALARM_C   = CW'(ALARM_TH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [CW-1:0] pc;
  logic [CW-1:0] ones_count_q, ones_count_d;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          pc_warn, pc_alarm, ack_ok;

  gas_popcount #(.WIDTH(WIDTH)) u_popcount (
    .bits_i  (window),
    .count_o (pc)
  );

  assign pc_warn  = (pc >= WARN_C);
  assign pc_alarm = (pc >= ALARM_C);

  // A fresh sample at or above warn level overrides a coincident acknowledge.
  assign ack_ok = ack && (ones_count_q < WARN_C) && !(sample_valid && pc_warn);

  assign ones_count_d = sample_valid ? pc : ones_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SAFE;
      ones_count_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ones_count_q <= ones_count_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SAFE, WARN: begin
        if (sample_valid) begin
          if (pc_alarm)     state_d = ALARM;
          else if (pc_warn) state_d = WARN;
          else              state_d = SAFE;
        end
      end
      ALARM: begin
        if (ack_ok) state_d = HOLD;
      end
      HOLD: begin
        if (sample_valid && pc_alarm)     state_d = ALARM;
        else if (hold_cnt_q == HOLD_LAST) state_d = SAFE;
      end
      default: state_d = SAFE;
    endcase
  end

  // Timer only runs while staying in HOLD, so every HOLD entry starts from zero.
  always_comb begin
    hold_cnt_d = '0;
    if ((state_q == HOLD) && (state_d == HOLD)) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
    end
  end

  always_comb begin
    warn        = (state_q == WARN);
    alarm       = (state_q == ALARM);
    valve_close = (state_q == ALARM) || (state_q == HOLD);
  end

  assign ones_count = ones_count_q;

`ifdef GAS_EVENT_COUNTER_EN
  logic [LEAK_W-1:0] leak_q, leak_d;
  logic              alarm_entry;

  assign alarm_entry = (state_d == ALARM) && (state_q != ALARM);
  assign leak_d      = alarm_entry ? sat_inc(leak_q) : leak_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leak_q <= '0;
    end else begin
      leak_q <= leak_d;
    end
  end

  assign leak_events = leak_q;
`else
  assign leak_events = '0;
`endif

endmodule

// File: tb/tb_gas_window_monitor.sv
// Scoreboarded bench for gas_window_monitor: scripted sample/ack sequences with expected
// outputs queued at drive time and compared one step after each clock edge.
module tb_gas_window_monitor;

`ifdef GAS_EVENT_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // {warn, alarm, valve_close} per state
  localparam logic [2:0] ST_S = 3'b000;
  localparam logic [2:0] ST_W = 3'b100;
  localparam logic [2:0] ST_A = 3'b011;
  localparam logic [2:0] ST_H = 3'b001;

  typedef struct packed {
    logic [3:0] oc;
    logic [2:0] wav;
    logic [7:0] le;
  } exp_t;

  typedef struct {
    logic [11:0] win;
    logic        sv;
    logic        ak;
    logic [3:0]  oc;
    logic [2:0]  wav;
    int          nle;
    int          rep;
  } row_t;

  logic        clk;
  logic        rst;
  logic [11:0] window;
  logic        sample_valid;
  logic        ack;
  logic [3:0]  ones_count;
  logic        warn;
  logic        alarm;
  logic        valve_close;
  logic [7:0]  leak_events;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  gas_window_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .window       (window),
    .sample_valid (sample_valid),
    .ack          (ack),
    .ones_count   (ones_count),
    .warn         (warn),
    .alarm        (alarm),
    .valve_close  (valve_close),
    .leak_events  (leak_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] le_exp(input int n);
    if (!CNT_EN) return 8'd0;
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  function automatic exp_t mk(input logic [3:0] oc, input logic [2:0] wav, input int nle);
    exp_t e;
    e.oc  = oc;
    e.wav = wav;
    e.le  = le_exp(nle);
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t g;
    g.oc  = ones_count;
    g.wav = {warn, alarm, valve_close};
    g.le  = leak_events;
    return g;
  endfunction

  task automatic cyc(input logic [11:0] w, input logic s, input logic a);
    window       = w;
    sample_valid = s;
    ack          = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, got;
    exp_q.push_back(mk(4'd0, ST_S, 0));
    e = exp_q.pop_front();
    got = obs();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL reset_idle got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", got.oc, got.wav, got.le, e.oc, e.wav, e.le);
    end
    exp_q.push_back(mk(4'd0, ST_S, 0));
    cyc(12'hFFF, 1'b1, 1'b1);
    e = exp_q.pop_front();
    got = obs();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL reset_strobe got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", got.oc, got.wav, got.le, e.oc, e.wav, e.le);
    end
    rst = 1'b1;
  endtask

  task automatic test_warn_alarm();
    row_t rows[6];
    rows = '{
      '{12'h007, 1'b1, 1'b0, 4'd3, ST_S, 0, 1},
      '{12'h00F, 1'b1, 1'b0, 4'd4, ST_W, 0, 1},
      '{12'h003, 1'b1, 1'b0, 4'd2, ST_S, 0, 1},
      '{12'h00F, 1'b1, 1'b0, 4'd4, ST_W, 0, 1},
      '{12'h000, 1'b0, 1'b0, 4'd4, ST_W, 0, 1},
      '{12'h0FF, 1'b1, 1'b0, 4'd8, ST_A, 1, 1}
    };
    foreach (rows[r]) begin
      for (int k = 0; k < rows[r].rep; k++) begin
        exp_t e, got;
        exp_q.push_back(mk(rows[r].oc, rows[r].wav, rows[r].nle));
        cyc(rows[r].win, rows[r].sv, rows[r].ak);
        e = exp_q.pop_front();
        got = obs();
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL warn_alarm row%0d/%0d got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", r, k, got.oc, got.wav, got.le, e.oc, e.wav, e.le);
        end
      end
    end
  endtask

  task automatic test_ack();
    row_t rows[4];
    rows = '{
      '{12'h000, 1'b0, 1'b1, 4'd8, ST_A, 1, 1},
      '{12'h001, 1'b1, 1'b1, 4'd1, ST_A, 1, 1},
      '{12'h000, 1'b0, 1'b1, 4'd1, ST_H, 1, 16},
      '{12'h000, 1'b0, 1'b1, 4'd1, ST_S, 1, 1}
    };
    foreach (rows[r]) begin
      for (int k = 0; k < rows[r].rep; k++) begin
        exp_t e, got;
        exp_q.push_back(mk(rows[r].oc, rows[r].wav, rows[r].nle));
        cyc(rows[r].win, rows[r].sv, rows[r].ak);
        e = exp_q.pop_front();
        got = obs();
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL ack_hold row%0d/%0d got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", r, k, got.oc, got.wav, got.le, e.oc, e.wav, e.le);
        end
      end
    end
  endtask

  task automatic test_ack_priority();
    row_t rows[7];
    rows = '{
      '{12'hFFF, 1'b1, 1'b0, 4'd12, ST_A, 2, 1},
      '{12'h000, 1'b1, 1'b1, 4'd0,  ST_A, 2, 1},
      '{12'h00F, 1'b1, 1'b1, 4'd4,  ST_A, 2, 1},
      '{12'h000, 1'b0, 1'b1, 4'd4,  ST_A, 2, 1},
      '{12'h001, 1'b1, 1'b0, 4'd1,  ST_A, 2, 1},
      '{12'h000, 1'b0, 1'b0, 4'd1,  ST_A, 2, 1},
      '{12'h000, 1'b0, 1'b1, 4'd1,  ST_H, 2, 1}
    };
    foreach (rows[r]) begin
      for (int k = 0; k < rows[r].rep; k++) begin
        exp_t e, got;
        exp_q.push_back(mk(rows[r].oc, rows[r].wav, rows[r].nle));
        cyc(rows[r].win, rows[r].sv, rows[r].ak);
        e = exp_q.pop_front();
        got = obs();
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL ack_priority row%0d/%0d got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", r, k, got.oc, got.wav, got.le, e.oc, e.wav, e.le);
        end
      end
    end
  endtask

  task automatic test_hold_restart();
    row_t rows[7];
    rows = '{
      '{12'h000, 1'b0, 1'b0, 4'd1,  ST_H, 2, 1},
      '{12'h07F, 1'b1, 1'b0, 4'd7,  ST_H, 2, 1},
      '{12'h000, 1'b0, 1'b0, 4'd7,  ST_H, 2, 1},
      '{12'hFFF, 1'b1, 1'b0, 4'd12, ST_A, 3, 1},
      '{12'h000, 1'b1, 1'b0, 4'd0,  ST_A, 3, 1},
      '{12'h000, 1'b0, 1'b1, 4'd0,  ST_H, 3, 16},
      '{12'h000, 1'b0, 1'b0, 4'd0,  ST_S, 3, 1}
    };
    foreach (rows[r]) begin
      for (int k = 0; k < rows[r].rep; k++) begin
        exp_t e, got;
        exp_q.push_back(mk(rows[r].oc, rows[r].wav, rows[r].nle));
        cyc(rows[r].win, rows[r].sv, rows[r].ak);
        e = exp_q.pop_front();
        got = obs();
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL hold_restart row%0d/%0d got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", r, k, got.oc, got.wav, got.le, e.oc, e.wav, e.le);
        end
      end
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      row_t rows[3];
      rows = '{
        '{12'hFFF, 1'b1, 1'b0, 4'd12, ST_A, 4 + n, 1},
        '{12'h000, 1'b1, 1'b1, 4'd0,  ST_A, 4 + n, 1},
        '{12'h000, 1'b0, 1'b1, 4'd0,  ST_H, 4 + n, 1}
      };
      foreach (rows[r]) begin
        exp_t e, got;
        exp_q.push_back(mk(rows[r].oc, rows[r].wav, rows[r].nle));
        cyc(rows[r].win, rows[r].sv, rows[r].ak);
        e = exp_q.pop_front();
        got = obs();
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL saturation entry%0d row%0d got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", n, r, got.oc, got.wav, got.le, e.oc, e.wav, e.le);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e, got;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(4'd0, ST_H, 263));
      cyc(12'h000, 1'b0, 1'b0);
      e = exp_q.pop_front();
      got = obs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL pre_reset_hold %0d got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", k, got.oc, got.wav, got.le, e.oc, e.wav, e.le);
      end
    end
    #2;
    rst = 1'b0;
    exp_q.push_back(mk(4'd0, ST_S, 0));
    #1;
    e = exp_q.pop_front();
    got = obs();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL async_reset_immediate got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", got.oc, got.wav, got.le, e.oc, e.wav, e.le);
    end
    exp_q.push_back(mk(4'd0, ST_S, 0));
    cyc(12'hFFF, 1'b1, 1'b1);
    e = exp_q.pop_front();
    got = obs();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL async_reset_held got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", got.oc, got.wav, got.le, e.oc, e.wav, e.le);
    end
    rst = 1'b1;
  endtask

  task automatic test_after_reset();
    row_t rows[3];
    rows = '{
      '{12'h000, 1'b0, 1'b0, 4'd0, ST_S, 0, 1},
      '{12'h00F, 1'b1, 1'b0, 4'd4, ST_W, 0, 1},
      '{12'h0FF, 1'b1, 1'b0, 4'd8, ST_A, 1, 1}
    };
    foreach (rows[r]) begin
      for (int k = 0; k < rows[r].rep; k++) begin
        exp_t e, got;
        exp_q.push_back(mk(rows[r].oc, rows[r].wav, rows[r].nle));
        cyc(rows[r].win, rows[r].sv, rows[r].ak);
        e = exp_q.pop_front();
        got = obs();
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL after_reset row%0d/%0d got oc=%0d wav=%b le=%0d need oc=%0d wav=%b le=%0d", r, k, got.oc, got.wav, got.le, e.oc, e.wav, e.le);
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    window       = '0;
    sample_valid = 1'b0;
    ack          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_warn_alarm();
    test_ack();
    test_ack_priority();
    test_hold_restart();
    test_saturation();
    test_async_reset();
    test_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
